// File: rtl/oob_reader_pkg.sv
// Shared types and constants for the guarded reader.
// OOB_READ_POISON_EN selects a poison fill pattern for out-of-range array reads.
package oob_reader_pkg;

  localparam logic [7:0] POISON_BYTE = 8'hA5;
  localparam int         MAX_DATA_W  = 64;

`ifdef OOB_READ_POISON_EN
  localparam logic [7:0] FILL_BYTE = POISON_BYTE;
`else
  localparam logic [7:0] FILL_BYTE = 8'h00;
`endif

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  rd_bit;
    logic                  oob_arr;
    logic                  oob_vec;
  } rsp_t;

  // Fill byte replicated across the low data_w bits; upper bits stay zero.
  function automatic logic [MAX_DATA_W-1:0] fill_word(input int data_w);
    logic [MAX_DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_DATA_W/8; i++)
      if (i < data_w/8) w[i*8 +: 8] = FILL_BYTE;
    return w;
  endfunction

endpackage

// File: rtl/oob_sat_counter.sv
// Saturating event counter: adds 0, 1 or 2 per cycle and sticks at all-ones.
module oob_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc1,
  input  logic             i_inc2,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + (CNT_W+1)'({i_inc2, i_inc1 & ~i_inc2});
    cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign o_cnt = cnt_q;

endmodule

// File: rtl/oob_guarded_reader.sv
// Array + bit-vector store with range-guarded writes and a 1-cycle valid/ready read path.
// OOB_READ_POISON_EN: out-of-range array reads return 8'hA5 replicated instead of zero.
module oob_guarded_reader
  import oob_reader_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ARR_SIZE = 4,
  parameter int VEC_SIZE = 8,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_valid,
  output logic              o_rd_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_bit,
  output logic              o_rsp_oob_arr,
  output logic              o_rsp_oob_vec,
  output logic [CNT_W-1:0]  o_oob_cnt
);

  localparam int AI_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
  localparam int VI_W = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;
  // Limits carry one extra bit so a size of 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] ARR_LIM = ARR_SIZE[ADDR_W:0];
  localparam logic [ADDR_W:0] VEC_LIM = VEC_SIZE[ADDR_W:0];
  localparam logic [MAX_DATA_W-1:0] FILL = fill_word(DATA_W);

  logic [DATA_W-1:0]   arr_q [ARR_SIZE];
  logic [DATA_W-1:0]   arr_d [ARR_SIZE];
  logic [VEC_SIZE-1:0] vec_q, vec_d;
  rsp_t                rsp_q, rsp_d;
  logic                rsp_valid_q, rsp_valid_d;

  logic wr_oob_arr, wr_oob_vec, rd_oob_arr, rd_oob_vec;
  logic rd_acc, wr_oob_ev, rd_oob_ev;

  assign wr_oob_arr = {1'b0, i_wr_addr} >= ARR_LIM;
  assign wr_oob_vec = {1'b0, i_wr_addr} >= VEC_LIM;
  assign rd_oob_arr = {1'b0, i_rd_addr} >= ARR_LIM;
  assign rd_oob_vec = {1'b0, i_rd_addr} >= VEC_LIM;

  assign o_rd_ready = !rsp_valid_q || i_rsp_ready;
  assign rd_acc     = i_rd_valid && o_rd_ready;

  always_comb begin
    arr_d = arr_q;
    vec_d = vec_q;
    if (i_wr_en && !wr_oob_arr) arr_d[i_wr_addr[AI_W-1:0]] = i_wr_data;
    if (i_wr_en && !wr_oob_vec) vec_d[i_wr_addr[VI_W-1:0]] = i_wr_data[0];
  end

  // Read samples the pre-write storage, so same-cycle write/read returns old data.
  always_comb begin
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q && !i_rsp_ready;
    if (rd_acc) begin
      rsp_valid_d   = 1'b1;
      rsp_d.data    = rd_oob_arr ? FILL : MAX_DATA_W'(arr_q[i_rd_addr[AI_W-1:0]]);
      rsp_d.rd_bit  = rd_oob_vec ? 1'b0 : vec_q[i_rd_addr[VI_W-1:0]];
      rsp_d.oob_arr = rd_oob_arr;
      rsp_d.oob_vec = rd_oob_vec;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      arr_q       <= '{default: '0};
      vec_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      arr_q       <= arr_d;
      vec_q       <= vec_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end

  assign wr_oob_ev = i_wr_en && (wr_oob_arr || wr_oob_vec);
  assign rd_oob_ev = rd_acc  && (rd_oob_arr || rd_oob_vec);

  oob_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc1 (wr_oob_ev ^ rd_oob_ev),
    .i_inc2 (wr_oob_ev & rd_oob_ev),
    .o_cnt  (o_oob_cnt)
  );

  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_data    = rsp_q.data[DATA_W-1:0];
  assign o_rsp_bit     = rsp_q.rd_bit;
  assign o_rsp_oob_arr = rsp_q.oob_arr;
  assign o_rsp_oob_vec = rsp_q.oob_vec;

endmodule

// File: tb/tb_oob_guarded_reader.sv
// Randomized + directed bench for oob_guarded_reader against a behavioural model.
module tb_oob_guarded_reader;

  localparam int DATA_W = 8, ARR_SIZE = 4, VEC_SIZE = 8, ADDR_W = 4, CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

`ifdef OOB_READ_POISON_EN
  localparam logic [DATA_W-1:0] EXP_FILL = {(DATA_W/8){8'hA5}};
`else
  localparam logic [DATA_W-1:0] EXP_FILL = '0;
`endif

  logic              i_clk = 1'b0, i_rst = 1'b1;
  logic              i_wr_en = 1'b0;
  logic [ADDR_W-1:0] i_wr_addr = '0;
  logic [DATA_W-1:0] i_wr_data = '0;
  logic              i_rd_valid = 1'b0;
  logic              o_rd_ready;
  logic [ADDR_W-1:0] i_rd_addr = '0;
  logic              o_rsp_valid;
  logic              i_rsp_ready = 1'b1;
  logic [DATA_W-1:0] o_rsp_data;
  logic              o_rsp_bit, o_rsp_oob_arr, o_rsp_oob_vec;
  logic [CNT_W-1:0]  o_oob_cnt;

  oob_guarded_reader #(
    .DATA_W(DATA_W), .ARR_SIZE(ARR_SIZE), .VEC_SIZE(VEC_SIZE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready), .i_rd_addr(i_rd_addr),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_bit(o_rsp_bit),
    .o_rsp_oob_arr(o_rsp_oob_arr), .o_rsp_oob_vec(o_rsp_oob_vec),
    .o_oob_cnt(o_oob_cnt)
  );

  always #5 i_clk = ~i_clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: plain storage plus one pending response slot.
  logic [DATA_W-1:0] m_arr [ARR_SIZE];
  bit                m_vec [VEC_SIZE];
  bit                m_valid, m_bit, m_oa, m_ov;
  logic [DATA_W-1:0] m_data;
  int                m_cnt;

  task automatic model_reset();
    foreach (m_arr[i]) m_arr[i] = '0;
    foreach (m_vec[i]) m_vec[i] = 1'b0;
    m_valid = 0; m_bit = 0; m_oa = 0; m_ov = 0; m_data = '0; m_cnt = 0;
  endtask

  // One clock: drive at negedge, check current outputs, advance model, wait next negedge.
  task automatic cyc(input bit we, input int wa, input int wd, input bit rv, input int ra, input bit rr);
    bit ready, acc;
    int n;
    i_wr_en = we; i_wr_addr = ADDR_W'(wa); i_wr_data = DATA_W'(wd);
    i_rd_valid = rv; i_rd_addr = ADDR_W'(ra); i_rsp_ready = rr;
    #1;
    ready = !m_valid || rr;
    chk("rd_ready", 64'(o_rd_ready), 64'(ready));
    chk("rsp_valid", 64'(o_rsp_valid), 64'(m_valid));
    if (m_valid) begin
      chk("rsp_data", 64'(o_rsp_data), 64'(m_data));
      chk("rsp_bit", 64'(o_rsp_bit), 64'(m_bit));
      chk("oob_arr", 64'(o_rsp_oob_arr), 64'(m_oa));
      chk("oob_vec", 64'(o_rsp_oob_vec), 64'(m_ov));
    end
    chk("oob_cnt", 64'(o_oob_cnt), 64'(m_cnt));
    n = 0;
    acc = rv && ready;
    if (acc) begin
      m_valid = 1;
      m_oa    = ra >= ARR_SIZE;
      m_ov    = ra >= VEC_SIZE;
      m_data  = m_oa ? EXP_FILL : m_arr[ra];
      m_bit   = m_ov ? 1'b0 : m_vec[ra];
      if (m_oa || m_ov) n++;
    end else if (rr) begin
      m_valid = 0;
    end
    if (we) begin
      if (wa < ARR_SIZE) m_arr[wa] = DATA_W'(wd);
      if (wa < VEC_SIZE) m_vec[wa] = wd[0];
      if (wa >= ARR_SIZE || wa >= VEC_SIZE) n++;
    end
    m_cnt = (m_cnt + n > CNT_MAX) ? CNT_MAX : m_cnt + n;
    @(negedge i_clk);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_valid", 64'(o_rsp_valid), 64'd0);
    chk("rst_ready", 64'(o_rd_ready), 64'd1);
    chk("rst_cnt", 64'(o_oob_cnt), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Cleared storage reads back zero.
    for (int a = 0; a < 4; a++) cyc(0, 0, 0, 1, a, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // In-range write then read.
    cyc(1, 2, 'h3C, 0, 0, 1);
    cyc(0, 0, 0, 1, 2, 1);
    #1 chk("rd2_data", 64'(o_rsp_data), 64'h3C);
    @(negedge i_clk);
    cyc(0, 0, 0, 0, 0, 1);

    // Fully OOB write is dropped; OOB reads flag and fill.
    cyc(1, 9, 'hFF, 0, 0, 1);
    cyc(0, 0, 0, 1, 9, 1);
    cyc(1, 5, 'h01, 1, 5, 1);
    cyc(0, 0, 0, 1, 5, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Same-cycle write/read to one address returns pre-write data.
    cyc(1, 1, 'h77, 1, 1, 1);
    cyc(0, 0, 0, 1, 1, 1);

    // Backpressure: response holds, then queued reads drain back-to-back.
    cyc(0, 0, 0, 1, 2, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 3, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, k, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Random traffic.
    for (int k = 0; k < 600; k++)
      cyc($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
          $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 9) < 7);

    // Saturation.
    for (int k = 0; k < 300; k++) cyc(0, 0, 0, 1, 15, 1);
    cyc(1, 12, 0, 1, 14, 1);
    #1 chk("cnt_sat", 64'(o_oob_cnt), 64'(CNT_MAX));
    @(negedge i_clk);

    // Asynchronous reset while a response is stalled.
    cyc(0, 0, 0, 1, 0, 0);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_valid", 64'(o_rsp_valid), 64'd0);
    chk("arst_cnt", 64'(o_oob_cnt), 64'd0);
    chk("arst_ready", 64'(o_rd_ready), 64'd1);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int a = 0; a < 6; a++) cyc(0, 0, 0, 1, a, 1);
    cyc(0, 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
